// File: rtl/park_pkg.sv
// Shared state and slot encodings for the parking mission sequencer.
package park_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CRUISE = 3'd1,
    SETTLE = 3'd2,
    PARK   = 3'd3,
    DONE   = 3'd4,
    FAULT  = 3'd5
  } state_t;

  localparam logic [1:0] PARK_NONE     = 2'b00;
  localparam logic [1:0] PARK_SLANT    = 2'b01;
  localparam logic [1:0] PARK_REVERSE  = 2'b10;
  localparam logic [1:0] PARK_PARALLEL = 2'b11;

endpackage

// File: rtl/park_sequencer_tick_gen.sv
// Free-running prescaler; tick_c is high for the last clk of every TICK-clk period.
module tick_gen #(
  parameter int unsigned TICK = 2400
) (
  input  logic clk,
  input  logic rst,
  output logic tick_c
);

  localparam int unsigned W = (TICK > 1) ? $clog2(TICK) : 1;

  logic [W-1:0] cnt;

  assign tick_c = (cnt == W'(TICK - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/park_sequencer.sv
// Mission controller: line-following cruise, debounced marker confirm, settle stop,
// timed parking manoeuvre with done/fault reporting to the top level.
module park_sequencer
  import park_pkg::*;
#(
  parameter int unsigned TICK         = 2400,
  parameter int unsigned DEB_TICKS    = 200,
  parameter int unsigned SETTLE_TICKS = 5000,
  parameter int unsigned LOST_TICKS   = 3000,
  parameter int unsigned PARK_TO      = 60000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] turn_in,
  input  logic       marker,
  input  logic [1:0] slot_type,
  input  logic       park_f,
  output logic       drive_en,
  output logic [1:0] park,
  output logic [4:0] turn_out,
  output logic [2:0] state_o,
  output logic       done,
  output logic       fault
);

  localparam int unsigned MAX_A = (DEB_TICKS > SETTLE_TICKS) ? DEB_TICKS : SETTLE_TICKS;
  localparam int unsigned MAX_B = (LOST_TICKS > PARK_TO) ? LOST_TICKS : PARK_TO;
  localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = $clog2(MAX_P + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_P);

  state_t        state, state_n;
  logic          tick_c;
  logic [CW-1:0] tcnt, deb_cnt, lost_cnt;
  logic [1:0]    guard;
  logic          armed;
  logic [1:0]    slot, slot_n;
  logic          clr_c, confirm_c, lost_c;
  logic          drive_en_n, done_n, fault_n;
  logic [1:0]    park_n;
  logic [4:0]    turn_n;

  tick_gen #(.TICK(TICK)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_c (tick_c)
  );

  assign confirm_c = (state == CRUISE) && tick_c && marker && armed &&
                     (deb_cnt >= CW'(DEB_TICKS - 1));
  assign lost_c    = (state == CRUISE) && tick_c && (turn_in == 5'b00000) &&
                     (lost_cnt >= CW'(LOST_TICKS - 1));
  assign clr_c     = abort || (state_n != state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state plus the values every output register will take at the same edge.
  always_comb begin
    state_n    = state;
    slot_n     = slot;
    drive_en_n = 1'b0;
    park_n     = PARK_NONE;
    turn_n     = 5'b00000;
    done_n     = 1'b0;
    fault_n    = 1'b0;

    case (state)
      IDLE: begin
        if (start) state_n = CRUISE;
      end
      CRUISE: begin
        if (confirm_c) begin
          slot_n = slot_type;
          if (slot_type != PARK_NONE) state_n = SETTLE;
        end else if (lost_c) begin
          state_n = FAULT;
        end
      end
      SETTLE: begin
        if (tick_c && (tcnt >= CW'(SETTLE_TICKS - 1))) state_n = PARK;
      end
      PARK: begin
        if ((guard == 2'd2) && !park_f) begin
          state_n = DONE;
        end else if (tick_c && (tcnt >= CW'(PARK_TO - 1))) begin
          state_n = FAULT;
        end
      end
      DONE:    state_n = DONE;
      FAULT:   state_n = FAULT;
      default: state_n = IDLE;
    endcase

    if (abort) state_n = IDLE;

    drive_en_n = (state_n == CRUISE);
    if ((state_n == PARK) || (state_n == DONE)) park_n = slot_n;
    if (drive_en_n) turn_n = turn_in;
    done_n  = (state_n == DONE);
    fault_n = (state_n == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drive_en <= 1'b0;
      park     <= PARK_NONE;
      turn_out <= 5'b00000;
      state_o  <= 3'd0;
      done     <= 1'b0;
      fault    <= 1'b0;
      slot     <= PARK_NONE;
    end else begin
      drive_en <= drive_en_n;
      park     <= park_n;
      turn_out <= turn_n;
      state_o  <= state_n;
      done     <= done_n;
      fault    <= fault_n;
      slot     <= slot_n;
    end
  end

  // Per-state timers, marker debounce and the post-entry park_f guard; all restart on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt     <= '0;
      deb_cnt  <= '0;
      lost_cnt <= '0;
      guard    <= 2'd0;
      armed    <= 1'b1;
    end else if (clr_c) begin
      tcnt     <= '0;
      deb_cnt  <= '0;
      lost_cnt <= '0;
      guard    <= 2'd0;
      armed    <= 1'b1;
    end else begin
      if (guard != 2'd2) guard <= guard + 2'd1;
      if (tick_c && (tcnt != CNT_MAX)) tcnt <= tcnt + CW'(1);
      if ((state == CRUISE) && tick_c) begin
        if (!marker) begin
          deb_cnt <= '0;
          armed   <= 1'b1;
        end else if (confirm_c) begin
          // Confirmed an empty slot: stay disarmed until the marker drops.
          deb_cnt <= '0;
          armed   <= 1'b0;
        end else if (armed && (deb_cnt != CNT_MAX)) begin
          deb_cnt <= deb_cnt + CW'(1);
        end
        if (turn_in != 5'b00000) begin
          lost_cnt <= '0;
        end else if (lost_cnt != CNT_MAX) begin
          lost_cnt <= lost_cnt + CW'(1);
        end
      end
    end
  end

endmodule
